axi_lite_apb_bridge_mc: RTL and testbench

//   AXI4-Lite slave to APB3/APB4 master bridge with NUM_SLV decoded APB peripheral slots (UART, GPIO, timers, ...).

---
 rtl/axi_lite_apb_bridge_mc_if.sv | 48 ++++
 rtl/axi_lite_apb_bridge_mc.sv | 175 +++++++++++++++++
 tb/tb_axi_lite_apb_bridge_mc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_apb_bridge_mc_if.sv
// Bus bundle for the AXI4-Lite to APB bridge: AXI-Lite slave port plus the decoded APB master port.
// The bridge uses the slave modport; the driving AXI master / APB peripheral model uses master.
interface axi_lite_apb_bridge_mc_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic [ADDR_W-1:0]         AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_W-1:0]         WDATA;
  logic [DATA_W/8-1:0]       WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDR_W-1:0]         ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_W-1:0]         RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W/8-1:0]       PSTRB;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  PRDATA, PREADY, PSLVERR,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output PRDATA, PREADY, PSLVERR,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/axi_lite_apb_bridge_mc.sv
// AXI4-Lite slave to multi-slot APB master bridge with address decode, DECERR and round-robin R/W arbitration.
// Define AXIAPB_TIMEOUT_EN to abort ACCESS phases after TIMEOUT cycles without PREADY.
module axi_lite_apb_bridge_mc #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_SLV    = 4,
  parameter int                SLV_ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int                TIMEOUT    = 255
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi_lite_apb_bridge_mc_if.slave        bus,
  output logic [2:0]                     bridge_state
);
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int STB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_WRESP  = 3'd3,
    S_RRESP  = 3'd4
  } state_e;

  if (NUM_SLV < 1 || NUM_SLV > 16 || (DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_cfg_check
    $error("axi_lite_apb_bridge_mc: unsupported parameter set");
  end

  state_e              state_q,   state_d;
  logic                last_wr_q, last_wr_d;
  logic                write_q,   write_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [STB_W-1:0]    wstrb_q,   wstrb_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [1:0]          resp_q,    resp_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
`ifdef AXIAPB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
`endif

  logic [DATA_W-1:0] prdata_slot [NUM_SLV];
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slot
    assign prdata_slot[gi] = bus.PRDATA[gi*DATA_W +: DATA_W];
  end

  // Grants only fire in IDLE; a write needs both AW and W so they handshake together.
  logic wr_pend, rd_pend, grant_wr, grant_rd;
  assign wr_pend  = bus.AWVALID && bus.WVALID;
  assign rd_pend  = bus.ARVALID;
  assign grant_wr = (state_q == S_IDLE) && !areset && wr_pend && (!rd_pend || !last_wr_q);
  assign grant_rd = (state_q == S_IDLE) && !areset && rd_pend && !grant_wr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      idx_q     <= '0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
`ifdef AXIAPB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      idx_q     <= idx_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
`ifdef AXIAPB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  logic [ADDR_W-1:0] req_addr, offset, slot;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    idx_d     = idx_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
`ifdef AXIAPB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    req_addr  = grant_wr ? bus.AWADDR : bus.ARADDR;
    offset    = req_addr - BASE_ADDR;
    slot      = offset >> SLV_ADDR_W;

    case (state_q)
      S_IDLE: begin
        if (grant_wr || grant_rd) begin
          last_wr_d = grant_wr;
          write_d   = grant_wr;
          addr_d    = req_addr;
          resp_d    = 2'b00;
          rdata_d   = '0;
          if (grant_wr) begin
            wdata_d = bus.WDATA;
            wstrb_d = bus.WSTRB;
          end
          // Addresses below the base wrap to a huge slot number and decode as DECERR too.
          if (slot < ADDR_W'(NUM_SLV)) begin
            idx_d   = slot[IDX_W-1:0];
            state_d = S_SETUP;
          end else begin
            resp_d  = 2'b11;
            state_d = grant_wr ? S_WRESP : S_RRESP;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef AXIAPB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.PREADY[idx_q]) begin
          resp_d  = bus.PSLVERR[idx_q] ? 2'b10 : 2'b00;
          if (!write_q) rdata_d = prdata_slot[idx_q];
          state_d = write_q ? S_WRESP : S_RRESP;
        end
`ifdef AXIAPB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_d  = 2'b10;
          rdata_d = '0;
          state_d = write_q ? S_WRESP : S_RRESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WRESP: if (bus.BREADY) state_d = S_IDLE;
      S_RRESP: if (bus.RREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.AWREADY  = grant_wr;
    bus.WREADY   = grant_wr;
    bus.ARREADY  = grant_rd;
    bus.BVALID   = (state_q == S_WRESP);
    bus.BRESP    = resp_q;
    bus.RVALID   = (state_q == S_RRESP);
    bus.RRESP    = resp_q;
    bus.RDATA    = rdata_q;
    bus.PSEL     = '0;
    if (state_q == S_SETUP || state_q == S_ACCESS) bus.PSEL = NUM_SLV'(1) << idx_q;
    bus.PENABLE  = (state_q == S_ACCESS);
    bus.PWRITE   = write_q;
    bus.PADDR    = addr_q;
    bus.PWDATA   = wdata_q;
    bus.PSTRB    = write_q ? wstrb_q : '0;
    bridge_state = state_q;
  end
endmodule

// File: tb/tb_axi_lite_apb_bridge_mc.sv
// Directed bench for axi_lite_apb_bridge_mc: stimulus queues expected B/R responses,
// a monitor pops and compares them on each handshake.
module tb_axi_lite_apb_bridge_mc;
`ifdef AXIAPB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic       aclk;
  logic       areset;
  logic [2:0] bridge_state;

  axi_lite_apb_bridge_mc_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  axi_lite_apb_bridge_mc #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_ADDR_W(12),
    .BASE_ADDR(32'h1000_0000), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus.slave), .bridge_state(bridge_state)
  );

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wait_cfg = 0;
  logic [3:0] err_mask = 4'b0000;
  int   acc_cnt  = 0;
  int   acc_total = 0;
  int   psel_seen = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // APB peripheral model: slot responds after wait_cfg wait states
  always @(negedge aclk) begin
    if (bus.PENABLE && bus.PSEL != 4'b0000) begin
      acc_cnt   = acc_cnt + 1;
      acc_total = acc_total + 1;
    end else begin
      acc_cnt = 0;
    end
    if (bus.PSEL != 4'b0000) psel_seen = psel_seen + 1;
    bus.PREADY  = (bus.PENABLE && acc_cnt > wait_cfg) ? bus.PSEL : 4'b0000;
    bus.PSLVERR = bus.PSEL & err_mask;
  end

  // Response monitor
  always @(negedge aclk) begin
    exp_t e;
    #2;
    if (!areset) begin
      if (bus.BVALID && bus.BREADY) begin
        if (exp_q.size() == 0) chk("unexpected_b_response", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("b_order", 1, {63'd0, e.is_wr});
          chk("bresp", {62'd0, bus.BRESP}, {62'd0, e.resp});
          $display("B response resp=%0b", bus.BRESP);
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        if (exp_q.size() == 0) chk("unexpected_r_response", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("r_order", 0, {63'd0, e.is_wr});
          chk("rresp", {62'd0, bus.RRESP}, {62'd0, e.resp});
          chk("rdata", {32'd0, bus.RDATA}, {32'd0, e.rdata});
          $display("R response resp=%0b data=0x%08h", bus.RRESP, bus.RDATA);
        end
      end
    end
  end

  task automatic push_exp(input logic w, input logic [1:0] r, input logic [31:0] d);
    exp_t e;
    e.is_wr = w; e.resp = r; e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    t = 0;
    @(negedge aclk);
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    #2;
    while (!(bus.AWREADY && bus.WREADY) && t < 100) begin
      @(negedge aclk); #2; t++;
    end
    chk("aw_w_handshake", {62'd0, bus.AWREADY, bus.WREADY}, 64'd3);
    @(negedge aclk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    int t;
    t = 0;
    @(negedge aclk);
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    #2;
    while (!bus.ARREADY && t < 100) begin
      @(negedge aclk); #2; t++;
    end
    chk("ar_handshake", {63'd0, bus.ARREADY}, 64'd1);
    @(negedge aclk);
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge aclk); t++;
    end
    chk("response_drain", exp_q.size(), 0);
    @(negedge aclk);
  endtask

  initial begin
    int t, base;
    areset = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    bus.PRDATA = {32'hCAFE_F00D, 32'h1234_5678, 32'hB1B1_B1B1, 32'hA0A0_0001};

    // Reset values
    repeat (3) @(negedge aclk);
    #2;
    chk("reset_psel_penable", {59'd0, bus.PSEL, bus.PENABLE}, 0);
    chk("reset_paddr_pwdata", {bus.PADDR, bus.PWDATA}, 0);
    chk("reset_pwrite_pstrb", {59'd0, bus.PWRITE, bus.PSTRB}, 0);
    chk("reset_valids_readies", {59'd0, bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
    chk("reset_rdata_resp", {28'd0, bus.RDATA, bus.BRESP, bus.RRESP}, 0);
    chk("reset_state", {61'd0, bridge_state}, 0);
    @(negedge aclk);
    areset = 1'b0;

    // Simultaneous AW/W/AR after reset: write first, then read
    push_exp(1'b1, 2'b00, 32'h0);
    push_exp(1'b0, 2'b00, 32'h1234_5678);
    fork
      axi_write(32'h1000_0008, 32'h1111_2222, 4'hF);
      axi_read(32'h1000_2004);
    join
    wait_idle();

    // Write 0x1000_1004, zero wait states: cycle-exact APB timing
    push_exp(1'b1, 2'b00, 32'h0);
    axi_write(32'h1000_1004, 32'hDEAD_BEEF, 4'hF);
    #2;
    chk("t1_setup_psel", {60'd0, bus.PSEL}, 64'h2);
    chk("t1_setup_penable", {63'd0, bus.PENABLE}, 0);
    chk("t1_setup_paddr", {32'd0, bus.PADDR}, 64'h1000_1004);
    chk("t1_setup_pwdata_pstrb_pwrite", {27'd0, bus.PWDATA, bus.PSTRB, bus.PWRITE}, {27'd0, 32'hDEAD_BEEF, 4'hF, 1'b1});
    @(negedge aclk); #2;
    chk("t1_access_psel_penable", {59'd0, bus.PSEL, bus.PENABLE}, {59'd0, 4'b0010, 1'b1});
    chk("t1_access_paddr_stable", {32'd0, bus.PADDR}, 64'h1000_1004);
    @(negedge aclk); #2;
    chk("t1_bvalid_cycle3", {63'd0, bus.BVALID}, 1);
    chk("t1_psel_dropped", {59'd0, bus.PSEL, bus.PENABLE}, 0);
    wait_idle();

    // Both pending after a write: read wins
    push_exp(1'b0, 2'b00, 32'hA0A0_0001);
    push_exp(1'b1, 2'b00, 32'h0);
    fork
      axi_write(32'h1000_3000, 32'h0000_0001, 4'h3);
      axi_read(32'h1000_0000);
    join
    wait_idle();

    // Read slot 2 with 3 wait states
    wait_cfg = 3;
    base = acc_total;
    push_exp(1'b0, 2'b00, 32'h1234_5678);
    axi_read(32'h1000_2000);
    #2;
    chk("t2_setup_psel", {60'd0, bus.PSEL}, 64'h4);
    chk("t2_read_pstrb_pwrite", {59'd0, bus.PSTRB, bus.PWRITE}, 0);
    wait_idle();
    chk("t2_access_cycles", acc_total - base, 4);
    wait_cfg = 0;

    // Out-of-range and boundary decodes
    base = psel_seen;
    push_exp(1'b0, 2'b11, 32'h0);
    axi_read(32'h2000_0000);
    wait_idle();
    chk("t3_no_psel", psel_seen - base, 0);
    push_exp(1'b0, 2'b00, 32'hCAFE_F00D);
    axi_read(32'h1000_3FFC);
    wait_idle();
    base = psel_seen;
    push_exp(1'b0, 2'b11, 32'h0);
    axi_read(32'h1000_4000);
    push_exp(1'b1, 2'b11, 32'h0);
    axi_write(32'h0FFF_FFFC, 32'h7777_7777, 4'hF);
    wait_idle();
    chk("decerr_no_psel", psel_seen - base, 0);

    // PSLVERR on slot 3 with BREADY held low
    err_mask = 4'b1000;
    bus.BREADY = 1'b0;
    push_exp(1'b1, 2'b10, 32'h0);
    axi_write(32'h1000_3010, 32'h55AA_55AA, 4'hF);
    t = 0;
    #2;
    while (!bus.BVALID && t < 50) begin
      @(negedge aclk); #2; t++;
    end
    chk("t5_bvalid_seen", {63'd0, bus.BVALID}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk); #2;
      chk("t5_bvalid_hold", {61'd0, bus.BVALID, bus.BRESP}, {61'd0, 1'b1, 2'b10});
    end
    @(negedge aclk);
    bus.BREADY = 1'b1;
    wait_idle();
    push_exp(1'b0, 2'b10, 32'hCAFE_F00D);
    axi_read(32'h1000_3008);
    wait_idle();
    err_mask = 4'b0000;

    // Reset asserted during ACCESS abandons the transfer
    wait_cfg = 20;
    axi_write(32'h1000_0010, 32'h0BAD_0BAD, 4'hF);
    @(negedge aclk);
    areset = 1'b1;
    #2;
    chk("rst_mid_in_access", {61'd0, bridge_state}, 2);
    @(negedge aclk); #2;
    chk("rst_mid_psel_penable", {59'd0, bus.PSEL, bus.PENABLE}, 0);
    chk("rst_mid_state_valids", {59'd0, bridge_state, bus.BVALID, bus.RVALID}, 0);
    areset = 1'b0;
    repeat (5) @(negedge aclk);
    #2;
    chk("rst_mid_stays_idle", {61'd0, bridge_state}, 0);
    wait_cfg = 0;

`ifdef AXIAPB_TIMEOUT_EN
    // PREADY never arrives: abort after TIMEOUT access cycles
    wait_cfg = 100000;
    base = acc_total;
    push_exp(1'b0, 2'b10, 32'h0);
    axi_read(32'h1000_1000);
    wait_idle();
    chk("t6_timeout_access_cycles", acc_total - base, 16);
    wait_cfg = 0;
`endif

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
